// File: rtl/neuro_spike_scheduler.sv
// neuro_spike_scheduler
// Collects spike pulses from four direction channels (0=E, 1=N, 2=W, 3=S),
// keeps a saturating pending count per channel, and issues one batched
// {dir, weight} packet per grant over a valid/ready handshake.
// Optional feature macro: SPIKE_SCHED_RR_EN selects round-robin arbitration;
// when undefined, the lowest nonzero channel index wins.
module neuro_spike_scheduler #(
  parameter int CNT_W    = 8,
  parameter int WEIGHT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          spike_in,
  input  logic                enable,
  input  logic [WEIGHT_W-1:0] step_weight,
  input  logic                ovf_clear,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [1:0]          pkt_dir,
  output logic [WEIGHT_W-1:0] pkt_weight,
  output logic                busy,
  output logic [3:0]          ovf
);

  localparam int PROD_W = CNT_W + WEIGHT_W;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          sync1;
  logic [3:0]          sync2;
  logic [3:0]          dly;
  logic [3:0]          spike_edge;
  logic [CNT_W-1:0]    count [4];
  logic [3:0]          nonzero;
  logic [3:0]          ovf_set;
  logic [1:0]          winner;
  logic                grant;
  logic                handshake;
  logic [PROD_W-1:0]   product;
  logic [WEIGHT_W-1:0] weight_sat;

  // Two-flop synchronizer plus a delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= spike_in;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign spike_edge = sync2 & ~dly;

  // Per-channel pending flags and overflow set conditions
  always_comb begin
    nonzero = '0;
    ovf_set = '0;
    for (int c = 0; c < 4; c++) begin
      nonzero[c] = (count[c] != '0);
      // A granted channel is reloaded, so an edge there never overflows
      ovf_set[c] = spike_edge[c] && (count[c] == '1) &&
                   !(grant && (winner == 2'(c)));
    end
  end

`ifdef SPIKE_SCHED_RR_EN
  logic [1:0] last;

  // Round-robin search starting one past the last served channel
  always_comb begin
    logic [1:0] idx;
    logic       found;
    idx    = '0;
    found  = 1'b0;
    winner = last + 2'd1;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && nonzero[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Pointer advances only once the packet has actually been accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 2'd3;
    end else if (handshake) begin
      last <= pkt_dir;
    end
  end
`else
  // Fixed priority: lowest nonzero channel index wins
  always_comb begin
    winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (nonzero[i]) begin
        winner = 2'(i);
      end
    end
  end
`endif

  assign grant     = (state == IDLE) && enable && (|nonzero);
  assign handshake = (state == ISSUE) && pkt_ready;

  // Full-width product, saturated to all-ones if any high bit is set
  always_comb begin
    product    = {{WEIGHT_W{1'b0}}, count[winner]} * {{CNT_W{1'b0}}, step_weight};
    weight_sat = (|product[PROD_W-1:WEIGHT_W]) ? '1 : product[WEIGHT_W-1:0];
  end

  // Pending counters: reload on grant, otherwise saturating increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (grant && (winner == 2'(c))) begin
          count[c] <= spike_edge[c] ? CNT_W'(1) : '0;
        end else if (spike_edge[c] && (count[c] != '1)) begin
          count[c] <= count[c] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{4{ovf_clear}}) | ovf_set;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   if (pkt_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Packet payload is captured at grant and held through the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_dir    <= '0;
      pkt_weight <= '0;
    end else if (grant) begin
      pkt_dir    <= winner;
      pkt_weight <= weight_sat;
    end
  end

  assign pkt_valid = (state == ISSUE);
  assign busy      = (state == ISSUE);

endmodule

// File: tb/tb_neuro_spike_scheduler.sv
// Directed testbench for neuro_spike_scheduler (default CNT_W=8, WEIGHT_W=16).
// Expected arbitration order follows SPIKE_SCHED_RR_EN when it is defined.
module tb_neuro_spike_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  spike_in;
  logic        enable;
  logic [15:0] step_weight;
  logic        ovf_clear;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  pkt_dir;
  logic [15:0] pkt_weight;
  logic        busy;
  logic [3:0]  ovf;

  int tests;
  int failed;

  neuro_spike_scheduler #(.CNT_W(8), .WEIGHT_W(16)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable),
    .step_weight(step_weight), .ovf_clear(ovf_clear), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_dir(pkt_dir), .pkt_weight(pkt_weight),
    .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per accepted packet
  always @(posedge clk) begin
    if (!rst && pkt_valid && pkt_ready)
      $display("[TB] pkt dir=%0d weight=%04h", pkt_dir, pkt_weight);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle-high, one-cycle-low pulse on a channel
  task automatic pulse(input int ch);
    spike_in[ch] = 1'b1;
    tick();
    spike_in[ch] = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0] order [8];
    logic [1:0] exp_order [5];
    int         n_pkt;
    bit         bad_w;
    bit         seen;

    tests = 0; failed = 0;
    rst = 1'b1; spike_in = '0; enable = 1'b0; step_weight = '0;
    ovf_clear = 1'b0; pkt_ready = 1'b0;
    tick(2);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dir", pkt_dir, 0);
    chk("rst_weight", pkt_weight, 0);
    rst = 1'b0;
    tick();

    // Single spike: packet 4 edges after the pulse, one cycle wide
    step_weight = 16'd5; enable = 1'b1; pkt_ready = 1'b1;
    spike_in[0] = 1'b1;
    tick();
    spike_in[0] = 1'b0;
    chk("single_lat1", pkt_valid, 0);
    tick();
    chk("single_lat2", pkt_valid, 0);
    tick();
    chk("single_lat3", pkt_valid, 0);
    tick();
    chk("single_valid", pkt_valid, 1);
    chk("single_dir", pkt_dir, 0);
    chk("single_weight", pkt_weight, 5);
    chk("single_cnt0", dut.count[0], 0);
    tick();
    chk("single_drop", pkt_valid, 0);

    // Batching with backpressure
    enable = 1'b0; pkt_ready = 1'b0; step_weight = 16'd10;
    pulse(1); pulse(1); pulse(1);
    tick(3);
    chk("batch_cnt1", dut.count[1], 3);
    chk("batch_idle", pkt_valid, 0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", pkt_valid, 1);
      chk("bp_dir", pkt_dir, 1);
      chk("bp_weight", pkt_weight, 30);
    end
    pkt_ready = 1'b1;
    tick();
    chk("bp_done", pkt_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pkt_valid) seen = 1'b1;
    end
    chk("bp_single_hs", seen, 0);

    // Arbitration: one pending spike per channel, plus a late channel-0 spike
    enable = 1'b0; step_weight = 16'd1;
    spike_in = 4'hF;
    tick();
    spike_in = 4'h0;
    tick(4);
    enable = 1'b1;
    n_pkt = 0; bad_w = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 1) spike_in[0] = 1'b1;
      if (i == 2) spike_in[0] = 1'b0;
      if (pkt_valid) begin
        if (n_pkt < 8) order[n_pkt] = pkt_dir;
        if (pkt_weight !== 16'd1) bad_w = 1'b1;
        n_pkt++;
      end
    end
`ifdef SPIKE_SCHED_RR_EN
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
`endif
    chk("arb_count", n_pkt, 5);
    chk("arb_weight_bad", bad_w, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("arb_order%0d", i), order[i], exp_order[i]);
    end

    // Saturation at exactly 255*257 = 65535 and counter overflow
    enable = 1'b0; step_weight = 16'h0101;
    repeat (256) pulse(2);
    tick(3);
    chk("sat_ovf", ovf, 4'b0100);
    chk("sat_cnt2", dut.count[2], 255);
    enable = 1'b1;
    tick();
    chk("sat_valid", pkt_valid, 1);
    chk("sat_dir", pkt_dir, 2);
    chk("sat_weight_edge", pkt_weight, 16'hFFFF);
    tick();
    enable = 1'b0;
    chk("sat_sticky", ovf, 4'b0100);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // 255 pulses reach max without overflow; one more collides with clear
    step_weight = 16'h0102;
    repeat (255) pulse(2);
    tick(3);
    chk("max_no_ovf", ovf, 0);
    chk("max_cnt2", dut.count[2], 255);
    spike_in[2] = 1'b1;
    tick();
    spike_in[2] = 1'b0;
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("set_wins_clear", ovf, 4'b0100);
    enable = 1'b1;
    tick();
    chk("sat2_valid", pkt_valid, 1);
    chk("sat2_weight", pkt_weight, 16'hFFFF);
    tick();
    enable = 1'b0;

    // Edge landing on the grant edge of the same channel
    step_weight = 16'd7;
    pulse(3);
    tick(3);
    chk("eg_cnt3_pre", dut.count[3], 1);
    spike_in[3] = 1'b1;
    tick();
    spike_in[3] = 1'b0;
    tick();
    enable = 1'b1; pkt_ready = 1'b1;
    tick();
    chk("eg_valid1", pkt_valid, 1);
    chk("eg_dir1", pkt_dir, 3);
    chk("eg_weight1", pkt_weight, 7);
    chk("eg_cnt3_hold", dut.count[3], 1);
    tick();
    chk("eg_gap", pkt_valid, 0);
    tick();
    chk("eg_valid2", pkt_valid, 1);
    chk("eg_weight2", pkt_weight, 7);
    tick();
    enable = 1'b0;

    // Zero step still issues a packet of weight 0
    step_weight = 16'd0;
    pulse(0);
    tick(3);
    enable = 1'b1;
    tick();
    chk("zero_valid", pkt_valid, 1);
    chk("zero_weight", pkt_weight, 0);
    tick();

    // Reset mid-packet: outputs and counters clear without a clock edge
    enable = 1'b0; pkt_ready = 1'b0; step_weight = 16'd3;
    spike_in = 4'b0011;
    tick();
    spike_in = 4'b0000;
    tick(4);
    enable = 1'b1;
    tick();
    chk("mid_valid", pkt_valid, 1);
    chk("mid_cnt1", dut.count[1], 1);
    chk("mid_ovf", ovf, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", pkt_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_cnt1", dut.count[1], 0);
    tick(2);
    rst = 1'b0;
    pkt_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pkt_valid) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
